// File: rtl/m65c02_pkg.sv
// M65C02 processor status word shared definitions.
// Flag classes, P bit positions, FSM encodings, reset image.
package m65c02_pkg;

  localparam logic [2:0] FSEL_NONE = 3'd0;
  localparam logic [2:0] FSEL_NZ   = 3'd1;
  localparam logic [2:0] FSEL_NZC  = 3'd2;
  localparam logic [2:0] FSEL_NZCV = 3'd3;
  localparam logic [2:0] FSEL_Z    = 3'd4;
  localparam logic [2:0] FSEL_BIT  = 3'd5;
  localparam logic [2:0] FSEL_LDP  = 3'd6;
  localparam logic [2:0] FSEL_NOP  = 3'd7;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_U = 5;
  localparam int P_B = 4;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_MASK = 2'd2;

  localparam logic [7:0] RST_P = 8'h34;

endpackage

// File: rtl/m65c02_psw_if.sv
// PSW unit bus: ALU result stream, interrupt request,
// stack push handshake and status outputs.
interface m65c02_psw_if;

  logic       Rdy;
  logic       Val;
  logic [2:0] FSel;
  logic [8:0] Out;
  logic       Z;
  logic       V;
  logic [7:0] M;
  logic       Int;
  logic       Brk;
  logic       PushAck;
  logic [7:0] PSW;
  logic [7:0] PushD;
  logic       PushVal;
  logic       Busy;

  modport master (
    output Rdy, Val, FSel, Out, Z, V, M,
    output Int, Brk, PushAck,
    input  PSW, PushD, PushVal, Busy
  );

  modport slave (
    input  Rdy, Val, FSel, Out, Z, V, M,
    input  Int, Brk, PushAck,
    output PSW, PushD, PushVal, Busy
  );

endinterface

// File: rtl/m65c02_psw_upd.sv
// Next-P function for one ALU result.
// Bit5 and B always read back as 1 in the live register.
module m65c02_psw_upd
  import m65c02_pkg::*;
(
  input  logic [2:0] fsel,
  input  logic [8:0] out,
  input  logic       z,
  input  logic       v,
  input  logic [7:0] m,
  input  logic [7:0] p,
  output logic [7:0] p_next
);

  logic rz;

  assign rz = ~|out[7:0];

  // Per flag class, overwrite only the flags it owns
  always_comb begin
    p_next = p;
    unique case (fsel)
      FSEL_NZ: begin
        p_next[P_N] = out[7];
        p_next[P_Z] = rz;
      end
      FSEL_NZC: begin
        p_next[P_N] = out[7];
        p_next[P_Z] = rz;
        p_next[P_C] = out[8];
      end
      FSEL_NZCV: begin
        p_next[P_N] = out[7];
        p_next[P_Z] = rz;
        p_next[P_C] = out[8];
        p_next[P_V] = v;
      end
      FSEL_Z: begin
        p_next[P_Z] = z;
      end
      FSEL_BIT: begin
        p_next[P_N] = m[7];
        p_next[P_V] = m[6];
        p_next[P_Z] = z;
      end
      FSEL_LDP: begin
        p_next = out[7:0];
      end
      default: begin
        p_next = p;
      end
    endcase
    p_next[P_U] = 1'b1;
    p_next[P_B] = 1'b1;
  end

endmodule

// File: rtl/m65c02_psw.sv
// M65C02 P register with IRQ/BRK entry push sequencer.
// IDLE -> PUSH (wait ack) -> MASK (set I, clear D) -> IDLE.
module m65c02_psw
  import m65c02_pkg::*;
#(
  parameter logic [7:0] pRstP = RST_P
) (
  input logic Clk,
  input logic Rst,
  m65c02_psw_if.slave bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] p;
  logic [7:0] p_upd;
  logic [7:0] p_flag;
  logic [7:0] p_nxt;
  logic [7:0] push_d;

  m65c02_psw_upd u_upd (
    .fsel   (bus.FSel),
    .out    (bus.Out),
    .z      (bus.Z),
    .v      (bus.V),
    .m      (bus.M),
    .p      (p),
    .p_next (p_upd)
  );

  // Flag update, then MASK forces I/D over any P load
  always_comb begin
    p_flag = bus.Val ? p_upd : p;
    p_nxt  = p_flag;
    if (state == ST_MASK) begin
      p_nxt[P_I] = 1'b1;
      p_nxt[P_D] = 1'b0;
    end
  end

  // Entry sequencer transitions; Int only seen in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.Int) state_nxt = ST_PUSH;
      ST_PUSH: if (bus.PushAck) state_nxt = ST_MASK;
      ST_MASK: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // All state advances only while the core is ready
  always_ff @(posedge Clk) begin
    if (Rst) begin
      p      <= pRstP;
      state  <= ST_IDLE;
      push_d <= 8'h00;
    end else if (bus.Rdy) begin
      p     <= p_nxt;
      state <= state_nxt;
      if (state == ST_IDLE && bus.Int) begin
        push_d <= {p_flag[7:5], bus.Brk, p_flag[3:0]};
      end
    end
  end

  assign bus.PSW     = p;
  assign bus.PushD   = push_d;
  assign bus.PushVal = (state == ST_PUSH);
  assign bus.Busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_m65c02_psw.sv
// Directed bench for m65c02_psw.
// Expected outputs queued at drive time, popped after the edge.
module tb_m65c02_psw;

  typedef struct {
    string      tag;
    logic [7:0] psw;
    logic       pv;
    logic       busy;
    logic [7:0] pd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  m65c02_psw_if bus ();

  m65c02_psw #(.pRstP(8'h34)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input string      tag,
    input logic       r,
    input logic       rdy,
    input logic       val,
    input logic [2:0] fsel,
    input logic [8:0] out,
    input logic       zi,
    input logic       vi,
    input logic [7:0] m,
    input logic       irq,
    input logic       brk,
    input logic       ack,
    input logic [7:0] e_psw,
    input logic       e_pv,
    input logic       e_busy,
    input logic [7:0] e_pd
  );
    exp_t e;
    rst         = r;
    bus.Rdy     = rdy;
    bus.Val     = val;
    bus.FSel    = fsel;
    bus.Out     = out;
    bus.Z       = zi;
    bus.V       = vi;
    bus.M       = m;
    bus.Int     = irq;
    bus.Brk     = brk;
    bus.PushAck = ack;
    e.tag  = tag;
    e.psw  = e_psw;
    e.pv   = e_pv;
    e.busy = e_busy;
    e.pd   = e_pd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.PSW === e.psw) else begin
      failures++;
      $error("FAIL %s.psw got=%h exp=%h", e.tag, bus.PSW, e.psw);
    end
    checks++;
    assert (bus.PushVal === e.pv) else begin
      failures++;
      $error("FAIL %s.pushval got=%b exp=%b", e.tag, bus.PushVal, e.pv);
    end
    checks++;
    assert (bus.Busy === e.busy) else begin
      failures++;
      $error("FAIL %s.busy got=%b exp=%b", e.tag, bus.Busy, e.busy);
    end
    checks++;
    assert (bus.PushD === e.pd) else begin
      failures++;
      $error("FAIL %s.pushd got=%h exp=%h", e.tag, bus.PushD, e.pd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    // tag rst rdy val fsel out z v m int brk ack | psw pv busy pd
    step("reset",  1, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h34, 0, 0, 8'h00);
    step("nzc",    0, 1, 1, 3'd2, 9'h100, 0, 0, 8'h00, 0, 0, 0,
         8'h37, 0, 0, 8'h00);
    step("nz",     0, 1, 1, 3'd1, 9'h080, 0, 0, 8'h00, 0, 0, 0,
         8'hB5, 0, 0, 8'h00);
    step("bit_rdy0", 0, 0, 1, 3'd5, 9'h000, 1, 0, 8'hC0, 0, 0, 0,
         8'hB5, 0, 0, 8'h00);
    step("bit",    0, 1, 1, 3'd5, 9'h000, 1, 0, 8'hC0, 0, 0, 0,
         8'hF7, 0, 0, 8'h00);
    step("nzcv",   0, 1, 1, 3'd3, 9'h17F, 0, 1, 8'h00, 0, 0, 0,
         8'h75, 0, 0, 8'h00);
    step("zonly",  0, 1, 1, 3'd4, 9'h0FF, 1, 0, 8'h00, 0, 0, 0,
         8'h77, 0, 0, 8'h00);
    step("none7",  0, 1, 1, 3'd7, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h77, 0, 0, 8'h00);
    step("none0",  0, 1, 1, 3'd0, 9'h100, 0, 0, 8'h00, 0, 0, 0,
         8'h77, 0, 0, 8'h00);
    step("ldp3b",  0, 1, 1, 3'd6, 9'h03B, 0, 0, 8'h00, 0, 0, 0,
         8'h3B, 0, 0, 8'h00);
    step("irq",    0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 1, 0, 0,
         8'h3B, 1, 1, 8'h2B);
    step("wait1",  0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h3B, 1, 1, 8'h2B);
    step("wait2_rdy0", 0, 0, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 1,
         8'h3B, 1, 1, 8'h2B);
    step("ack",    0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 1,
         8'h3B, 0, 1, 8'h2B);
    step("mask",   0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h37, 0, 0, 8'h2B);
    step("ldp31",  0, 1, 1, 3'd6, 9'h031, 0, 0, 8'h00, 0, 0, 0,
         8'h31, 0, 0, 8'h2B);
    step("brk_val", 0, 1, 1, 3'd1, 9'h000, 0, 0, 8'h00, 1, 1, 0,
         8'h33, 1, 1, 8'h33);
    step("int_in_push", 0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 1, 0, 0,
         8'h33, 1, 1, 8'h33);
    step("ack2",   0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 1,
         8'h33, 0, 1, 8'h33);
    step("mask_ldp", 0, 1, 1, 3'd6, 9'h009, 0, 0, 8'h00, 0, 0, 0,
         8'h35, 0, 0, 8'h33);
    step("irq2",   0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 1, 0, 0,
         8'h35, 1, 1, 8'h25);
    step("rst_push", 1, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h34, 0, 0, 8'h00);
    step("post_rst", 0, 1, 0, 3'd0, 9'h000, 0, 0, 8'h00, 0, 0, 0,
         8'h34, 0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
